// File: rtl/clock_ctrl.sv
// clock_ctrl: run/halt/step sequencer driving the clock generator's stop input.
// Commands (halt > step > run) move an HALT/RUN/BURST FSM; BURST counts
// generator ticks down to zero and then halts with a one-cycle done pulse.
// Optional feature macro: CLOCK_CTRL_BREAK_EN adds a level break input that
// halts a free run and reports it with a one-cycle o_break pulse.
module clock_ctrl #(
    parameter int p_count_width = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_run,
    input  logic                     i_halt,
    input  logic                     i_step,
    input  logic [p_count_width-1:0] i_count,
    input  logic                     i_tick,
    output logic                     o_stop,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [p_count_width-1:0] o_remain
`ifdef CLOCK_CTRL_BREAK_EN
    ,
    input  logic                     i_break,
    output logic                     o_break
`endif
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic [p_count_width-1:0] CNT_ONE  = p_count_width'(1);
    localparam logic [p_count_width-1:0] CNT_ZERO = '0;

    state_t                   state_q, state_d;
    logic [p_count_width-1:0] remain_q, remain_d;
    logic                     done_d;
    logic                     brk_d;
    logic                     brk_in;

`ifdef CLOCK_CTRL_BREAK_EN
    assign brk_in = i_break;
`else
    assign brk_in = 1'b0;
`endif

    // Next-state, burst counter and pulse decode; halt always wins.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        brk_d    = 1'b0;
        case (state_q)
            S_HALT: begin
                if (i_halt) begin
                    state_d = S_HALT;
                end else if (i_step) begin
                    if (i_count == CNT_ZERO) begin
                        // Empty burst completes immediately without leaving HALT.
                        remain_d = CNT_ZERO;
                        done_d   = 1'b1;
                    end else begin
                        remain_d = i_count;
                        state_d  = S_BURST;
                    end
                end else if (i_run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_HALT;
                end else if (brk_in) begin
                    state_d = S_HALT;
                    brk_d   = 1'b1;
                end else if (i_step) begin
                    if (i_count == CNT_ZERO) begin
                        remain_d = CNT_ZERO;
                        done_d   = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        remain_d = i_count;
                        state_d  = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (i_halt) begin
                    // Abort keeps the untaken count visible.
                    state_d = S_HALT;
                end else if (i_tick) begin
                    if (remain_q <= CNT_ONE) begin
                        remain_d = CNT_ZERO;
                        done_d   = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        remain_d = remain_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d  = S_HALT;
                remain_d = CNT_ZERO;
            end
        endcase
    end

    // State and registered outputs; stop/busy follow the new state directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_HALT;
            remain_q <= CNT_ZERO;
            o_stop   <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            o_stop   <= (state_d == S_HALT);
            o_busy   <= (state_d != S_HALT);
            o_done   <= done_d;
        end
    end

    assign o_remain = remain_q;

`ifdef CLOCK_CTRL_BREAK_EN
    // Break-taken pulse, one cycle after the break is sampled in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_break <= 1'b0;
        else       o_break <= brk_d;
    end
`else
    logic unused_brk;
    assign unused_brk = brk_d;
`endif

endmodule
